// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - state encoding and constants for the DIV/DIVU sequencer
package div_sequencer_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ABS_A = 3'd1;
    localparam logic [2:0] ABS_B = 3'd2;
    localparam logic [2:0] ITER  = 3'd3;
    localparam logic [2:0] FIX_Q = 3'd4;
    localparam logic [2:0] FIX_R = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam int          ITERS        = 32;
    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/Sub.sv
// rtl/Sub.sv - 32-bit subtractor res = sr - tg - bin with borrow (CF) and signed overflow (OF)
module Sub (
    input  logic [31:0] sr,
    input  logic [31:0] tg,
    input  logic        bin,
    output logic [31:0] res,
    output logic        CF,
    output logic        OF
);

    assign {CF, res} = {1'b0, sr} - {1'b0, tg} - {32'b0, bin};
    assign OF        = (sr[31] ^ tg[31]) & (sr[31] ^ res[31]);

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring DIV/DIVU controller time-sharing one Sub unit
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = div_sequencer_pkg::ITERS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [2:0]       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, orig_a_q, orig_a_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             signed_q, signed_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] sub_sr, sub_tg, sub_res, partial;
    logic             sub_cf, sub_of_unused, success;

    Sub u_sub (
        .sr  (sub_sr),
        .tg  (sub_tg),
        .bin (1'b0),
        .res (sub_res),
        .CF  (sub_cf),
        .OF  (sub_of_unused)
    );

    assign partial = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    // A set shifted-out bit means the partial remainder already exceeds any divisor.
    assign success = r_q[WIDTH-1] | ~sub_cf;

    always_comb begin
        sub_sr = '0;
        sub_tg = '0;
        case (state_q)
            ABS_A:   sub_tg = a_q;
            ABS_B:   sub_tg = b_q;
            ITER: begin
                sub_sr = partial;
                sub_tg = b_q;
            end
            FIX_Q:   sub_tg = q_q;
            FIX_R:   sub_tg = r_q;
            default: sub_tg = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        orig_a_d = orig_a_q;
        r_d      = r_q;
        q_d      = q_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        signed_d = signed_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = dividend;
                    b_d      = divisor;
                    orig_a_d = dividend;
                    signed_d = is_signed;
                    neg_q_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_d  = is_signed & dividend[WIDTH-1];
                    state_d  = ABS_A;
                end
            end
            ABS_A: begin
                if (signed_q && a_q[WIDTH-1]) a_d = sub_res;
                state_d = ABS_B;
            end
            ABS_B: begin
                if (signed_q && b_q[WIDTH-1]) b_d = sub_res;
                r_d     = '0;
                q_d     = a_q;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                r_d = success ? sub_res : partial;
                q_d = {q_q[WIDTH-2:0], success};
                if (cnt_q == 5'(ITERS - 1)) state_d = FIX_Q;
                else                        cnt_d   = cnt_q + 5'd1;
            end
            FIX_Q: begin
                if (neg_q_q) q_d = sub_res;
                state_d = FIX_R;
            end
            FIX_R: begin
                // Results are registered here so they are already visible during DONE.
                if (neg_r_q) r_d = sub_res;
                dbz_d   = (b_q == '0);
                quot_d  = dbz_d ? DBZ_QUOTIENT : q_q;
                rem_d   = dbz_d ? orig_a_q : r_d;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            orig_a_q <= '0;
            r_q      <= '0;
            q_q      <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            signed_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            orig_a_q <= orig_a_d;
            r_q      <= r_d;
            q_q      <= q_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            signed_q <= signed_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer with directed vectors
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    div_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done seen at cycle %0d with no pending request", cyc);
            end else begin
                e = sbq.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                check("done_latency_cycle", cyc, e.due);
                check("busy_in_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, output int acc);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int nd0);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (n_done > nd0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within 60 cycles, got none expected one");
        end
    endtask

    task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        int acc;
        int nd0;
        exp_t e;
        nd0 = n_done;
        issue(s, a, b, acc);
        e.q = eq; e.r = er; e.dbz = edbz; e.due = acc + 36;
        sbq.push_back(e);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        wait_done(nd0);
    endtask

    initial begin
        int acc;
        int nd0;
        exp_t e;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0);
        run(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE, 1'b0);
        run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
        run(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        run(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
        run(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
        run(1'b0, 32'd6, 32'd3, 32'h0000_0002, 32'h0000_0000, 1'b0);

        // Start requests while busy must be dropped, not queued.
        nd0 = n_done;
        issue(1'b0, 32'd100, 32'd7, acc);
        e.q = 32'd14; e.r = 32'd2; e.dbz = 1'b0; e.due = acc + 36;
        sbq.push_back(e);
        while (cyc < acc + 9) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        while (cyc < acc + 20) @(negedge clk);
        start = 1'b0;
        check("busy_during_ignored_start", {31'b0, busy}, 32'd1);
        wait_done(nd0);
        repeat (40) @(negedge clk);
        check("single_done_count", n_done - nd0, 32'd1);

        // Synchronous reset mid-operation discards the division.
        nd0 = n_done;
        issue(1'b0, 32'd100, 32'd7, acc);
        while (cyc < acc + 19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        check("midreset_dbz", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_done", n_done - nd0, 32'd0);
        run(1'b0, 32'd9, 32'd3, 32'h0000_0003, 32'h0000_0000, 1'b0);

        repeat (5) @(negedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
